// File: rtl/apb_slave_mem.sv
// APB completer terminating the bus in a word-addressed, reset-cleared register memory.
// Wait states are only implemented when APB_SLV_WAIT_EN is defined; otherwise every access is zero-wait.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic                    mem_we;
`ifdef APB_SLV_WAIT_EN
    logic [3:0]              cnt_q, cnt_d;
`endif

    // Upper address bits fold onto the same words, so the memory aliases every MEM_DEPTH words.
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [IDX_W-1:0]        addr_idx;
    logic                    unused_word_hi;
    logic                    setup;

    assign word_addr      = PADDR >> OFF_W;
    assign addr_idx       = word_addr[IDX_W-1:0];
    assign unused_word_hi = ^word_addr[ADDR_WIDTH-1:IDX_W];
    assign setup          = PSELx && !PENABLE;

    assign PREADY = ready_q;
    assign PRDATA = rdata_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    idx_d   = addr_idx;
                    wr_d    = PWRITE;
                    wdata_d = PWDATA;
`ifdef APB_SLV_WAIT_EN
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                        if (!PWRITE) rdata_d = mem_q[addr_idx];
                    end else begin
                        state_d = S_WAIT;
                    end
`else
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    if (!PWRITE) rdata_d = mem_q[addr_idx];
`endif
                end
            end
`ifdef APB_SLV_WAIT_EN
            S_WAIT: begin
                if (!PSELx) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                        if (!wr_q) rdata_d = mem_q[idx_q];
                    end
                end
            end
`endif
            S_DONE: begin
                // Write commits only on a sampled completion; an abort leaves memory untouched.
                if (!PSELx) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end else if (PENABLE && ready_q) begin
                    mem_we  = wr_q;
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: directed scenarios plus randomized traffic against a word-array model.
// Expected latency follows APB_SLV_WAIT_EN (WAIT_CYCLES honoured when defined, zero otherwise).
module tb_apb_slave_mem;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int MEM_DEPTH   = 256;
  localparam int WAIT_CYCLES = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int EFF_WAIT = WAIT_CYCLES;
`else
  localparam int EFF_WAIT = 0;
`endif

  logic                  PCLK = 1'b0;
  logic                  PRESETn = 1'b0;
  logic [ADDR_WIDTH-1:0] PADDR = '0;
  logic                  PSELx = 1'b0;
  logic                  PENABLE = 1'b0;
  logic                  PWRITE = 1'b0;
  logic [DATA_WIDTH-1:0] PWDATA = '0;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0] ref_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ref_prdata;

  apb_slave_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PADDR  (PADDR),
    .PSELx  (PSELx),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PREADY (PREADY),
    .PRDATA (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % MEM_DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = '0;
    ref_prdata = '0;
  endtask

  // Full APB transfer; reports access-phase wait count, PRDATA when PREADY seen, PREADY after completion.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input bit scramble, output logic [31:0] rd, output int waits,
                      output logic ready_after);
    PADDR = addr; PWRITE = wr; PWDATA = wd; PSELx = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (scramble) begin
      PADDR = $urandom; PWRITE = ~wr; PWDATA = $urandom;
    end
    waits = 0;
    while (PREADY !== 1'b1 && waits <= 40) begin
      @(posedge PCLK); #1;
      waits++;
    end
    rd = PRDATA;
    @(posedge PCLK); #1;
    ready_after = PREADY;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int waits; logic ra;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if (PREADY !== 1'b0 || PRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: PREADY=%b PRDATA=%h, required 0 / 00000000", PREADY, PRDATA);
    end
    model_reset();
    @(negedge PCLK); PRESETn = 1'b1;
    xfer(32'h14, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    checks++;
    if (waits != EFF_WAIT || rd !== ref_mem[5] || ra !== 1'b0) begin
      errors++;
      $display("FAIL reset_read_idx5: waits=%0d rd=%h ready_after=%b, required %0d / %h / 0",
               waits, rd, ra, EFF_WAIT, ref_mem[5]);
    end
    ref_prdata = ref_mem[5];
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int waits; logic ra;
    xfer(32'h40, 1'b1, 32'hDEAD_BEEF, 1'b0, rd, waits, ra);
    ref_mem[idx_of(32'h40)] = 32'hDEAD_BEEF;
    checks++;
    if (waits != EFF_WAIT || ra !== 1'b0 || PRDATA !== ref_prdata) begin
      errors++;
      $display("FAIL b2b_write: waits=%0d ready_after=%b PRDATA=%h, required %0d / 0 / %h",
               waits, ra, PRDATA, EFF_WAIT, ref_prdata);
    end
    xfer(32'h40, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    checks++;
    if (waits != EFF_WAIT || rd !== 32'hDEAD_BEEF || ra !== 1'b0) begin
      errors++;
      $display("FAIL b2b_readback: waits=%0d rd=%h ready_after=%b, required %0d / deadbeef / 0",
               waits, rd, ra, EFF_WAIT);
    end
    ref_prdata = rd;
  endtask

  task automatic test_alias();
    logic [31:0] rd; int waits; logic ra;
    xfer(32'h400, 1'b1, 32'h1234_5678, 1'b0, rd, waits, ra);
    ref_mem[idx_of(32'h400)] = 32'h1234_5678;
    xfer(32'h000, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    checks++;
    if (rd !== 32'h1234_5678 || waits != EFF_WAIT) begin
      errors++;
      $display("FAIL alias_wrap: rd=%h waits=%0d, required 12345678 / %0d", rd, waits, EFF_WAIT);
    end
    xfer(32'h003, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alias_offset: rd=%h, required 12345678", rd);
    end
    ref_prdata = rd;
  endtask

  task automatic test_enable_without_setup();
    logic [31:0] rd; int waits; logic ra; logic seen;
    seen = 1'b0;
    PADDR = 32'h80; PWRITE = 1'b1; PWDATA = $urandom | 32'h1; PSELx = 1'b1; PENABLE = 1'b1;
    repeat (3) begin
      @(posedge PCLK); #1;
      seen = seen | PREADY;
    end
    PSELx = 1'b0; PENABLE = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL enable_no_setup_ready: PREADY seen=%b, required 0", seen);
    end
    xfer(32'h80, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    checks++;
    if (rd !== ref_mem[idx_of(32'h80)]) begin
      errors++;
      $display("FAIL enable_no_setup_mem: rd=%h, required %h", rd, ref_mem[idx_of(32'h80)]);
    end
    ref_prdata = rd;
  endtask

  task automatic test_abort();
    logic [31:0] rd; int waits; logic ra; logic seen;
    PADDR = 32'h10; PWRITE = 1'b1; PWDATA = 32'hAAAA_AAAA; PSELx = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    seen = PREADY;
    if (EFF_WAIT > 1) begin
      @(posedge PCLK); #1;
      seen = seen | PREADY;
    end
    PSELx = 1'b0; PENABLE = 1'b0;
    checks++;
    if (seen !== (EFF_WAIT == 0)) begin
      errors++;
      $display("FAIL abort_ready_before_drop: PREADY seen=%b, required %b", seen, EFF_WAIT == 0);
    end
    @(posedge PCLK); #1;
    checks++;
    if (PREADY !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready_after_drop: PREADY=%b, required 0", PREADY);
    end
    xfer(32'h10, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    checks++;
    if (rd !== ref_mem[idx_of(32'h10)] || waits != EFF_WAIT) begin
      errors++;
      $display("FAIL abort_no_write: rd=%h waits=%0d, required %h / %0d",
               rd, waits, ref_mem[idx_of(32'h10)], EFF_WAIT);
    end
    ref_prdata = rd;
  endtask

  task automatic test_random();
    logic [31:0] rd; int waits; logic ra;
    logic [31:0] a; logic [31:0] d; logic wr; int idx; int gap;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 10);
      d = $urandom;
      wr = 1'($urandom_range(0, 1));
      idx = idx_of(a);
      xfer(a, wr, d, 1'($urandom_range(0, 1)), rd, waits, ra);
      checks++;
      if (waits != EFF_WAIT || ra !== 1'b0) begin
        errors++;
        $display("FAIL rand_latency[%0d]: waits=%0d ready_after=%b, required %0d / 0",
                 n, waits, ra, EFF_WAIT);
      end
      if (wr) begin
        ref_mem[idx] = d;
        checks++;
        if (PRDATA !== ref_prdata) begin
          errors++;
          $display("FAIL rand_prdata_hold[%0d]: PRDATA=%h, required %h", n, PRDATA, ref_prdata);
        end
      end else begin
        checks++;
        if (rd !== ref_mem[idx]) begin
          errors++;
          $display("FAIL rand_read[%0d]: addr=%h rd=%h, required %h", n, a, rd, ref_mem[idx]);
        end
        ref_prdata = ref_mem[idx];
      end
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge PCLK);
      if (gap > 0) #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int waits; logic ra; logic [31:0] x;
    x = $urandom | 32'h1;
    xfer(32'h20, 1'b1, x, 1'b0, rd, waits, ra);
    ref_mem[idx_of(32'h20)] = x;
    xfer(32'h20, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    ref_prdata = rd;
    PADDR = 32'h20; PWRITE = 1'b1; PWDATA = ~x; PSELx = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if (PREADY !== 1'b0 || PRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_async: PREADY=%b PRDATA=%h, required 0 / 00000000", PREADY, PRDATA);
    end
    model_reset();
    PSELx = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK); PRESETn = 1'b1;
    xfer(32'h20, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    checks++;
    if (rd !== ref_mem[idx_of(32'h20)] || waits != EFF_WAIT) begin
      errors++;
      $display("FAIL reset_mid_read20: rd=%h waits=%0d, required %h / %0d",
               rd, waits, ref_mem[idx_of(32'h20)], EFF_WAIT);
    end
    xfer(32'h40, 1'b0, 32'h0, 1'b0, rd, waits, ra);
    checks++;
    if (rd !== ref_mem[idx_of(32'h40)]) begin
      errors++;
      $display("FAIL reset_mid_mem_clear: rd=%h, required %h", rd, ref_mem[idx_of(32'h40)]);
    end
    ref_prdata = rd;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alias();
    test_enable_without_setup();
    test_abort();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
